// File: rtl/frame_buf_sched.sv
// ---------------------------------------------------------------------------
// frame_buf_sched
//
// Triple-buffer scheduler for a video frame store in DDR. Three buffer slots
// are rotated between a writer (W), the most recently completed frame (L)
// and the reader (R). The writer never stalls: each finished frame is parked
// in L. The reader picks up L at the start of each displayed frame, or
// repeats its current buffer when nothing new has arrived.
//
// Parameters
//   ADDR_WIDTH  DDR byte-address width
//   BASE_ADDR   start address of buffer 0
//   FRAME_SIZE  byte stride between consecutive buffers
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   wr_frame_done  pulse: writer finished the current frame
//   rd_frame_start pulse: reader begins a new frame
//   wr_buf_idx     buffer the writer fills (0..2)
//   rd_buf_idx     buffer the reader displays (0..2)
//   wr_base_addr   BASE_ADDR + wr_buf_idx*FRAME_SIZE
//   rd_base_addr   BASE_ADDR + rd_buf_idx*FRAME_SIZE
//   rd_valid       reader buffer holds a completed frame
//   frame_ready    an unread completed frame waits in L
//   drop_cnt       completed frames overwritten before being read (saturating)
//   repeat_cnt     reader starts with no new frame available (saturating)
// ---------------------------------------------------------------------------
module frame_buf_sched #(
  parameter int                    ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 28'h000_0000,
  parameter logic [ADDR_WIDTH-1:0] FRAME_SIZE = 28'h020_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_frame_done,
  input  logic                  rd_frame_start,
  output logic [1:0]            wr_buf_idx,
  output logic [1:0]            rd_buf_idx,
  output logic [ADDR_WIDTH-1:0] wr_base_addr,
  output logic [ADDR_WIDTH-1:0] rd_base_addr,
  output logic                  rd_valid,
  output logic                  frame_ready,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           repeat_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_READY = 2'd1,
    S_STALE = 2'd2
  } state_t;

  // Buffer start addresses, truncated to ADDR_WIDTH by the declared width.
  localparam logic [ADDR_WIDTH-1:0] ADDR0 = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] ADDR1 = BASE_ADDR + FRAME_SIZE;
  localparam logic [ADDR_WIDTH-1:0] ADDR2 = BASE_ADDR + (FRAME_SIZE << 1);

  state_t      state, state_nxt;
  logic [1:0]  w_idx, l_idx, r_idx;
  logic [1:0]  w_nxt, l_nxt, r_nxt;
  logic        valid_nxt;
  logic [15:0] drop_nxt, rep_nxt;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [1:0] idx);
    case (idx)
      2'd0:    addr_of = ADDR0;
      2'd1:    addr_of = ADDR1;
      default: addr_of = ADDR2;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // State register. Base addresses are registered from the next-state
  // indices so that each address changes on the same edge as its index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_EMPTY;
      w_idx        <= 2'd0;
      l_idx        <= 2'd1;
      r_idx        <= 2'd2;
      rd_valid     <= 1'b0;
      drop_cnt     <= 16'd0;
      repeat_cnt   <= 16'd0;
      wr_base_addr <= ADDR0;
      rd_base_addr <= ADDR2;
    end else begin
      state        <= state_nxt;
      w_idx        <= w_nxt;
      l_idx        <= l_nxt;
      r_idx        <= r_nxt;
      rd_valid     <= valid_nxt;
      drop_cnt     <= drop_nxt;
      repeat_cnt   <= rep_nxt;
      wr_base_addr <= addr_of(w_nxt);
      rd_base_addr <= addr_of(r_nxt);
    end
  end

  // Next-state logic. Every transition only swaps or rotates the three
  // slot indices, so they remain a permutation of {0,1,2} by construction.
  // A simultaneous write-done and read-start hands the just-finished frame
  // straight to the reader; whatever sat in L is superseded.
  always_comb begin
    state_nxt = state;
    w_nxt     = w_idx;
    l_nxt     = l_idx;
    r_nxt     = r_idx;
    valid_nxt = rd_valid;
    drop_nxt  = drop_cnt;
    rep_nxt   = repeat_cnt;
    case ({wr_frame_done, rd_frame_start})
      2'b10: begin
        w_nxt     = l_idx;
        l_nxt     = w_idx;
        state_nxt = S_READY;
        if (state == S_READY) drop_nxt = sat_inc(drop_cnt);
      end
      2'b01: begin
        if (state == S_READY) begin
          r_nxt     = l_idx;
          l_nxt     = r_idx;
          state_nxt = S_STALE;
          valid_nxt = 1'b1;
        end else begin
          rep_nxt = sat_inc(repeat_cnt);
        end
      end
      2'b11: begin
        r_nxt     = w_idx;
        w_nxt     = l_idx;
        l_nxt     = r_idx;
        state_nxt = S_STALE;
        valid_nxt = 1'b1;
        if (state == S_READY) drop_nxt = sat_inc(drop_cnt);
      end
      default: ;
    endcase
  end

  // Outputs taken directly from registered state, so no input-to-output
  // combinational path exists.
  always_comb begin
    wr_buf_idx  = w_idx;
    rd_buf_idx  = r_idx;
    frame_ready = (state == S_READY);
  end

endmodule
